// File: rtl/muldiv_stall_ctrl.sv
`default_nettype none
// ============================================================================
// muldiv_stall_ctrl : decode-stage front-end stall for multi-cycle RV64M ops
// Revision 1.0
// ============================================================================
module muldiv_stall_ctrl #(
    parameter int WORD_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 34,
    parameter bit EN_DIV    = 1'b1,
    localparam int CNT_W    = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WORD_BITS-1:0] Inst_ROM_in,
    input  logic [DATA_BITS-1:0] Addr_64,
    input  logic [WORD_BITS-1:0] IF_ID_addr,
    input  logic [WORD_BITS-1:0] IF_ID_inst,
    input  logic                 PC_stall,
    input  logic                 flush,
    input  logic                 div_done,
    output logic                 mulstall,
    output logic                 busy,
    output logic                 op_is_div,
    output logic [CNT_W-1:0]     cycles_left
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_COOL = 2'd2
    } state_t;

    localparam logic [6:0] c_OP_REG   = 7'b0110011;
    localparam logic [6:0] c_OP_REG32 = 7'b0111011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_F7_M     = 7'b0000001;
    localparam logic [CNT_W-1:0] c_MUL_LAT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] c_DIV_LAT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_div_q, op_div_d;

    logic [6:0]         w_op;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [2:0]         w_id_f3;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_br_in_id;
    logic               w_addr_differs;
    logic               w_trigger;
    logic [CNT_W-1:0]   w_lat;
    logic               w_unused_bits;

    assign w_op    = Inst_ROM_in[6:0];
    assign w_f3    = Inst_ROM_in[14:12];
    assign w_f7    = Inst_ROM_in[31:25];
    assign w_id_f3 = IF_ID_inst[14:12];

    assign w_unused_bits = ^{Inst_ROM_in[24:15], Inst_ROM_in[11:7],
                             IF_ID_inst[31:15], IF_ID_inst[11:7]};

    assign w_is_mul = (w_f7 == c_F7_M) &&
                      (((w_op == c_OP_REG) && !w_f3[2]) ||
                       ((w_op == c_OP_REG32) && (w_f3 == 3'b000)));

    assign w_is_div = EN_DIV && (w_f7 == c_F7_M) &&
                      (((w_op == c_OP_REG) && w_f3[2]) ||
                       ((w_op == c_OP_REG32) && w_f3[2]));

    // Conditional branches only; f3 010/011 are not valid branch encodings
    assign w_br_in_id = (IF_ID_inst[6:0] == c_OP_BR) && (w_id_f3[2:1] != 2'b01);

    // A word already latched into IF/ID must not re-trigger the stall
    assign w_addr_differs = (DATA_BITS'(IF_ID_addr) != Addr_64);

    assign w_trigger = !RST && (state_q == S_IDLE) && (w_is_mul || w_is_div) &&
                       !w_br_in_id && !PC_stall && !flush && w_addr_differs;

    assign w_lat = w_is_div ? c_DIV_LAT : c_MUL_LAT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_trigger) begin
                        op_div_d = w_is_div;
                        if (w_lat == c_ONE) begin
                            state_d = S_COOL;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_BUSY;
                            cnt_d   = w_lat - c_ONE;
                        end
                    end
                end
                S_BUSY: begin
                    if ((div_done && op_div_q) || (cnt_q == c_ONE)) begin
                        state_d = S_COOL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - c_ONE;
                    end
                end
                S_COOL: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        mulstall    = w_trigger || ((state_q == S_BUSY) && !flush && !RST);
        busy        = (state_q == S_BUSY) && !RST;
        op_is_div   = op_div_q;
        cycles_left = (state_q == S_BUSY) ? cnt_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_muldiv_stall_ctrl : two configurations driven in lockstep vs. a cycle model
// Revision 1.0
// ============================================================================
module tb_muldiv_stall_ctrl;

    localparam int CW = 6;
    localparam logic [31:0] I_MUL  = 32'h02B50533;
    localparam logic [31:0] I_DIV  = 32'h02B54533;
    localparam logic [31:0] I_NOP  = 32'h00000013;
    localparam logic [31:0] I_BEQ  = 32'h00B50463;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] inst, id_addr, id_inst;
    logic [63:0] addr64;
    logic        pc_stall, flush, div_done;

    logic          st_a, busy_a, div_a, st_b, busy_b, div_b;
    logic [CW-1:0] left_a, left_b;

    int checks = 0;
    int errors = 0;
    int stall_cnt [2];
    int busy_cnt  [2];

    // Reference: remaining stall cycles while busy, a cool-down flag, last class
    int m_rem  [2];
    bit m_cool [2];
    bit m_div  [2];
    int m_mul_lat [2] = '{3, 1};
    bit m_en_div  [2] = '{1'b1, 1'b0};

    always #5 CLK = ~CLK;

    muldiv_stall_ctrl dut_a (
        .CLK(CLK), .RST(RST), .Inst_ROM_in(inst), .Addr_64(addr64),
        .IF_ID_addr(id_addr), .IF_ID_inst(id_inst), .PC_stall(pc_stall),
        .flush(flush), .div_done(div_done), .mulstall(st_a), .busy(busy_a),
        .op_is_div(div_a), .cycles_left(left_a)
    );

    muldiv_stall_ctrl #(.MUL_LAT(1), .DIV_LAT(34), .EN_DIV(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .Inst_ROM_in(inst), .Addr_64(addr64),
        .IF_ID_addr(id_addr), .IF_ID_inst(id_inst), .PC_stall(pc_stall),
        .flush(flush), .div_done(div_done), .mulstall(st_b), .busy(busy_b),
        .op_is_div(div_b), .cycles_left(left_b)
    );

    // 0 = not an M op, 1 = multiply, 2 = divide
    function automatic int op_class(logic [31:0] w);
        if (w[31:25] != 7'd1) return 0;
        if (w[6:0] == 7'h33) return (w[14:12] < 3'd4) ? 1 : 2;
        if (w[6:0] == 7'h3B) begin
            if (w[14:12] == 3'd0) return 1;
            if (w[14:12] >= 3'd4) return 2;
        end
        return 0;
    endfunction

    function automatic bit is_branch(logic [31:0] w);
        return (w[6:0] == 7'h63) && (w[14:12] != 3'd2) && (w[14:12] != 3'd3);
    endfunction

    function automatic int eff_class(int k);
        int c = op_class(inst);
        if (c == 2 && !m_en_div[k]) c = 0;
        return c;
    endfunction

    function automatic bit m_trig(int k);
        return !RST && m_rem[k] == 0 && !m_cool[k] && eff_class(k) != 0 &&
               !is_branch(id_inst) && !pc_stall && !flush &&
               (64'(id_addr) != addr64);
    endfunction

    function automatic bit m_idle();
        return m_rem[0] == 0 && !m_cool[0] && m_rem[1] == 0 && !m_cool[1];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_cool[k] = 0; m_div[k] = 0;
        end
    endtask

    task automatic check_now();
        for (int k = 0; k < 2; k++) begin
            bit e_st, e_busy, e_div;
            int e_left;
            string p;
            p      = (k == 0) ? "a" : "b";
            e_busy = !RST && m_rem[k] > 0;
            e_st   = m_trig(k) || (e_busy && !flush);
            e_left = RST ? 0 : m_rem[k];
            e_div  = RST ? 1'b0 : m_div[k];
            chk({p, ".mulstall"}, 64'((k == 0) ? st_a : st_b), 64'(e_st));
            chk({p, ".busy"}, 64'((k == 0) ? busy_a : busy_b), 64'(e_busy));
            chk({p, ".op_is_div"}, 64'((k == 0) ? div_a : div_b), 64'(e_div));
            chk({p, ".cycles_left"}, 64'((k == 0) ? left_a : left_b), 64'(e_left));
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int lat;
            bit t;
            t = m_trig(k);
            if (RST || flush) begin
                if (RST) m_div[k] = 0;
                m_rem[k] = 0; m_cool[k] = 0;
            end else if (m_rem[k] > 0) begin
                if ((div_done && m_div[k]) || m_rem[k] == 1) begin
                    m_rem[k] = 0; m_cool[k] = 1;
                end else begin
                    m_rem[k]--;
                end
            end else if (m_cool[k]) begin
                m_cool[k] = 0;
            end else if (t) begin
                m_div[k] = (eff_class(k) == 2);
                lat      = m_div[k] ? 34 : m_mul_lat[k];
                if (lat == 1) m_cool[k] = 1;
                else          m_rem[k]  = lat - 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        check_now();
        if (st_a === 1'b1) stall_cnt[0]++;
        if (st_b === 1'b1) stall_cnt[1]++;
        if (busy_a === 1'b1) busy_cnt[0]++;
        if (busy_b === 1'b1) busy_cnt[1]++;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic clear_counts();
        stall_cnt = '{0, 0};
        busy_cnt  = '{0, 0};
    endtask

    task automatic drain();
        int n = 0;
        inst = I_NOP; flush = 0; div_done = 0; pc_stall = 0;
        while (!m_idle() && n < 60) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(m_idle()), 64'(1));
    endtask

    initial begin
        logic [31:0] pool [16];
        logic [31:0] idpool [6];
        pool = '{32'h02B50533, 32'h02B51533, 32'h02B52533, 32'h02B53533,
                 32'h02B5053B, 32'h02B54533, 32'h02B55533, 32'h02B56533,
                 32'h02B57533, 32'h02B5453B, 32'h02B5553B, 32'h02B5653B,
                 32'h02B5753B, 32'h00B50533, 32'h02B5153B, 32'h04B50533};
        idpool = '{I_BEQ, 32'h00B51463, 32'h00B54463, 32'h00B52463, I_NOP, 32'h00C58633};

        RST = 1; inst = I_NOP; addr64 = 64'h104; id_addr = 32'h100;
        id_inst = I_NOP; pc_stall = 0; flush = 0; div_done = 0;
        model_reset();
        clear_counts();
        repeat (2) cycle();
        RST = 0;

        // T1: multiply stall length, cool-down, re-stall on held word
        inst = I_MUL;
        repeat (4) cycle();
        chk("t1.stall_cycles_a", 64'(stall_cnt[0]), 64'(3));
        chk("t1.busy_cycles_a", 64'(busy_cnt[0]), 64'(2));
        chk("t6.stall_cycles_b", 64'(stall_cnt[1]), 64'(2));
        cycle();
        chk("t1.restall_a", 64'(stall_cnt[0]), 64'(4));
        drain();

        // T2: divide with early completion at cycles_left == 20
        clear_counts();
        inst = I_DIV;
        repeat (16) begin
            div_done = (m_rem[0] == 20);
            cycle();
        end
        chk("t2.stall_cycles_a", 64'(stall_cnt[0]), 64'(15));
        chk("t2.op_is_div_a", 64'(div_a), 64'(1));
        chk("t6.div_no_stall_b", 64'(stall_cnt[1]), 64'(0));
        drain();

        // T3: branch in IF/ID, equal address, other stall source
        clear_counts();
        inst = I_MUL; id_inst = I_BEQ;
        repeat (3) cycle();
        id_inst = I_NOP; id_addr = 32'h104;
        repeat (3) cycle();
        id_addr = 32'h100; pc_stall = 1;
        repeat (3) cycle();
        chk("t3.no_stall_a", 64'(stall_cnt[0]), 64'(0));
        chk("t3.no_stall_b", 64'(stall_cnt[1]), 64'(0));
        drain();

        // Upper PC bits set: zero-extended IF/ID address differs, so it stalls
        clear_counts();
        addr64 = 64'h1_0000_0100; inst = I_MUL;
        cycle();
        chk("zext.trigger_a", 64'(stall_cnt[0]), 64'(1));
        drain();
        addr64 = 64'h104;

        // T4: flush on second busy cycle of a divide
        inst = I_DIV;
        repeat (2) cycle();
        flush = 1;
        cycle();
        flush = 0; inst = I_NOP;
        cycle();
        chk("t4.cycles_left_a", 64'(left_a), 64'(0));
        drain();

        // T5: asynchronous reset mid-busy
        inst = I_MUL;
        repeat (2) cycle();
        #2 RST = 1;
        model_reset();
        #1;
        chk("t5.async_mulstall_a", 64'(st_a), 64'(0));
        chk("t5.async_busy_a", 64'(busy_a), 64'(0));
        check_now();
        cycle();
        #3 RST = 0;
        clear_counts();
        repeat (3) cycle();
        chk("t5.full_stall_a", 64'(stall_cnt[0]), 64'(3));
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            inst     = pool[$urandom_range(0, 15)];
            id_inst  = idpool[$urandom_range(0, 5)];
            addr64   = {($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0, 32'h200 + 32'($urandom_range(0, 3) * 4)};
            id_addr  = 32'h200 + 32'($urandom_range(0, 3) * 4);
            pc_stall = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            div_done = ($urandom_range(0, 7) == 0);
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
